// File: rtl/four_bit_greater_than_pkg.sv
// Shared constants for the four_bit_greater_than comparator: default operand
// width and the 2-bit result encoding.
package four_bit_greater_than_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [1:0] GT = 2'b10;
    localparam logic [1:0] EQ = 2'b01;
    localparam logic [1:0] LT = 2'b00;

    // Collapse the cascade's final gt/eq pair into one result code.
    function automatic logic [1:0] encode_result(input logic gt, input logic eq);
        if (gt) begin
            return GT;
        end else if (eq) begin
            return EQ;
        end
        return LT;
    endfunction

endpackage

// File: rtl/four_bit_greater_than_compare_cell.sv
// One-bit slice of an MSB-first magnitude comparator cascade.
module compare_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic eq_in,
    output logic gt_out,
    output logic eq_out
);

    // A higher slice that already differed wins; otherwise this bit decides.
    assign gt_out = gt_in | (eq_in & a_bit & ~b_bit);
    assign eq_out = eq_in & ~(a_bit ^ b_bit);

endmodule

// File: rtl/four_bit_greater_than.sv
// Registered unsigned compare of A = switch[upper half] against
// B = switch[lower half]; exactly one of z/eq/lt is set after the first edge.
module four_bit_greater_than
    import four_bit_greater_than_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   switch,
    output logic                 z,
    output logic                 eq,
    output logic                 lt
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   gt_chain;
    logic [WIDTH:0]   eq_chain;
    logic [1:0]       result_code;
    logic             z_d;
    logic             eq_d;
    logic             lt_d;

    assign a = switch[2*WIDTH-1:WIDTH];
    assign b = switch[WIDTH-1:0];

    // Chain seed: nothing has differed yet above the MSB.
    assign gt_chain[WIDTH] = 1'b0;
    assign eq_chain[WIDTH] = 1'b1;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        compare_cell u_cell (
            .a_bit  (a[i]),
            .b_bit  (b[i]),
            .gt_in  (gt_chain[i+1]),
            .eq_in  (eq_chain[i+1]),
            .gt_out (gt_chain[i]),
            .eq_out (eq_chain[i])
        );
    end

    // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
    always_comb begin
        result_code = encode_result(gt_chain[0], eq_chain[0]);
        z_d         = (result_code == GT);
        eq_d        = (result_code == EQ);
        lt_d        = ~gt_chain[0] & ~eq_chain[0];
    end

    // NOTE: non-blocking assignments and an asynchronous reset clear all three flops at once, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z  <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
        end else begin
            z  <= z_d;
            eq <= eq_d;
            lt <= lt_d;
        end
    end

endmodule

// File: tb/tb_four_bit_greater_than.sv
// Self-checking bench for four_bit_greater_than: directed sequences, exhaustive
// sweep, random values, hold and asynchronous-reset behaviour.
module tb_four_bit_greater_than;

    logic       clk;
    logic       rst_n;
    logic [7:0] switch;
    logic       z;
    logic       eq;
    logic       lt;

    int passed;
    int total;

    four_bit_greater_than dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .switch (switch),
        .z      (z),
        .eq     (eq),
        .lt     (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer compare of the two nibbles, as {z, eq, lt}.
    function automatic logic [2:0] model(input logic [7:0] sw);
        int a;
        int b;
        a = int'(sw[7:4]);
        b = int'(sw[3:0]);
        return {a > b, a == b, a < b};
    endfunction

    task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed {z,eq,lt}=%b expected %b", tag, observed, expected);
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic [7:0] sw, input string tag);
        @(negedge clk);
        switch = sw;
        @(posedge clk);
        #1;
        check($sformatf("%s sw=%h", tag, sw), {z, eq, lt}, model(sw));
        check($sformatf("%s onehot sw=%h", tag, sw), {2'b00, $onehot({z, eq, lt})}, 3'b001);
    endtask

    logic [7:0] seq_a [6] = '{8'h00, 8'h80, 8'h88, 8'h9C, 8'hDC, 8'hFE};
    logic [7:0] seq_b [4] = '{8'h46, 8'hFF, 8'hF7, 8'h0F};
    logic       z_a   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       z_b   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        switch = 8'h80;

        // Reset held across several clock edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset hold", {z, eq, lt}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after release, before edge", {z, eq, lt}, 3'b000);
        @(posedge clk);
        #1;
        check("first edge after release", {z, eq, lt}, 3'b100);

        // Directed sequences with spec-stated z values as well as the model.
        for (int i = 0; i < 6; i++) begin
            apply(seq_a[i], "seq_a");
            check($sformatf("seq_a z[%0d]", i), {2'b00, z}, {2'b00, z_a[i]});
        end
        for (int i = 0; i < 4; i++) begin
            apply(seq_b[i], "seq_b");
            check($sformatf("seq_b z[%0d]", i), {2'b00, z}, {2'b00, z_b[i]});
        end

        // Boundaries.
        apply(8'h00, "bound 0/0");
        apply(8'hFF, "bound 15/15");
        apply(8'hF0, "bound 15/0");
        apply(8'h0F, "bound 0/15");
        apply(8'h87, "msb decides");
        apply(8'h78, "msb decides");

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) begin
            apply(8'(v), "sweep");
        end

        // Random values.
        for (int n = 0; n < 200; n++) begin
            apply(8'($urandom), "random");
        end

        // Mid-cycle change must not reach the outputs before the next edge.
        apply(8'h0F, "pre hold");
        @(negedge clk);
        switch = 8'hF0;
        #2;
        check("hold mid-cycle", {z, eq, lt}, 3'b001);
        @(posedge clk);
        #1;
        check("hold next edge", {z, eq, lt}, 3'b100);

        // Asynchronous reset pulse between edges while z=1.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset immediate", {z, eq, lt}, 3'b000);
        @(posedge clk);
        #1;
        check("reset across edge", {z, eq, lt}, 3'b000);
        @(negedge clk);
        switch = 8'h3A;
        rst_n  = 1'b1;
        #1;
        check("release no edge", {z, eq, lt}, 3'b000);
        @(posedge clk);
        #1;
        check("first load after reset", {z, eq, lt}, model(8'h3A));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
